fir_host_sequencer: RTL and testbench
=====================================

FIR_HOST_SEQUENCER -- requirements
Module: fir_host_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk, n_rst.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum cycles to wait for modwait to rise after a request.
REQ-003 SHALL have these ports:
- clk  in  1  system clock
- n_rst  in  1  async active-low reset
- sample_in  in  16  sample from host
- sample_valid  in  1  host sample offered
- sample_ready  out  1  sample accepted this cycle
- coeff_in  in  16  coefficient from host
- coeff_valid  in  1  host coefficient offered
- coeff_ready  out  1  coefficient accepted this cycle
- modwait  in  1  filter controller busy
- err  in  1  filter controller error
- fir_out  in  16  filter result
- sample_data  out  16  registered sample to datapath
- fir_coefficient  out  16  registered coefficient to datapath
- data_ready  out  1  sample request to controller
- load_coeff  out  1  coefficient request to controller
- result  out  16  captured filter result
- result_valid  out  1  one-cycle result strobe
- result_err  out  1  result or request failed
- coeff_done  out  1  one-cycle strobe when a 4-coefficient set completes
- busy  out  1  sequencer not in IDLE

Function
REQ-004 All outputs SHALL be registered.
REQ-005 States SHALL be IDLE, DR_HOLD, DR_RUN, LC_ACCEPT, LC_HOLD, LC_RUN.
REQ-006 In IDLE with sample_valid=1: sample_ready=1 for that cycle, sample_in latched into sample_data, next state DR_HOLD with data_ready=1.
REQ-007 In IDLE with sample_valid=0 and coeff_valid=1: coeff_ready=1, coeff_in latched into fir_coefficient, coefficient index reset to 0, next state LC_HOLD with load_coeff=1.
REQ-008 If sample_valid and coeff_valid are both high in IDLE, the sample SHALL win.
REQ-009 DR_HOLD: data_ready SHALL stay 1 through the first cycle modwait=1 is observed; on the following edge data_ready=0 and state becomes DR_RUN.
REQ-010 DR_RUN: on the first cycle modwait=0, result<=fir_out, result_err<=err, result_valid pulses 1 for exactly one cycle, state returns to IDLE.
REQ-011 LC_HOLD: load_coeff SHALL stay 1 through the first cycle modwait=1 is observed, then deassert on the next edge; state becomes LC_RUN.
REQ-012 LC_RUN: on modwait=0, if index<3 then index increments and state becomes LC_ACCEPT; if index=3 then coeff_done pulses one cycle and state becomes IDLE.
REQ-013 LC_ACCEPT: waits for coeff_valid; on coeff_valid=1, coeff_ready=1 for that cycle, latches coeff_in, and moves to LC_HOLD. sample_valid SHALL be ignored until the full set of 4 is done.
REQ-014 data_ready and load_coeff SHALL never be high in the same cycle.
REQ-015 Timeout: in DR_HOLD or LC_HOLD, if modwait is not seen within TIMEOUT cycles, the request SHALL drop and the state SHALL return to IDLE with result_err=1.
  - DR_HOLD timeout: result_valid pulses.
  - LC_HOLD timeout: coeff_done pulses and the coefficient set is abandoned.
REQ-016 result and result_err SHALL hold until the next capture. sample_data and fir_coefficient SHALL hold until the next accept.
REQ-017 busy=1 in every state except IDLE.

Reset
REQ-018 n_rst=0 SHALL immediately force:
- state IDLE, index 0;
- all outputs 0, including result, sample_data and fir_coefficient.
REQ-019 A reset mid-sequence SHALL abandon the sequence without any strobe.

Structure
REQ-020 Package fir_pkg SHALL hold the state enum, NUM_COEFF=4 and DATA_W=16.
REQ-021 The timeout SHALL use one flex_counter instance, cleared on entry to DR_HOLD/LC_HOLD and enabled while in those states.

Verification
REQ-022 Sample flow: sample_in=16'h0123 with valid in IDLE; modwait rises 1 cycle later and falls 10 cycles after that with fir_out=16'h00F0, err=0 -> data_ready high exactly 2 cycles; result=16'h00F0, result_valid for 1 cycle, result_err=0.
REQ-023 Coefficient set: four coefficients 16'h0020, 16'h0040, 16'h0040, 16'h0020, controller modwait high 1 cycle per load -> four load_coeff pulses of 2 cycles each, fir_coefficient matches at each pulse, one coeff_done.
REQ-024 Overflow: controller returns modwait=0 with err=1 -> result_valid=1, result_err=1.
REQ-025 Priority: sample_valid and coeff_valid both high in IDLE -> sample_ready=1, coeff_ready=0; the coefficient is accepted after the result strobe.
REQ-026 Timeout: modwait held 0 after a sample request -> data_ready drops after 15 cycles, result_err=1, state IDLE.
REQ-027 Reset during LC_RUN at index 2 -> all outputs 0 immediately, no coeff_done, next coeff_valid restarts at index 0.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR host sequencer.
package fir_pkg;

    localparam int unsigned NUM_COEFF = 4;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned IDX_W     = $clog2(NUM_COEFF);

    typedef enum logic [2:0] {
        IDLE,
        DR_HOLD,
        DR_RUN,
        LC_ACCEPT,
        LC_HOLD,
        LC_RUN
    } state_t;

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter with programmable rollover value and match flag.
module flex_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    input  logic [WIDTH-1:0] rollover_val,
    output logic             rollover_flag
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_enable) begin
            if (count == rollover_val) begin
                count <= WIDTH'(1);
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    assign rollover_flag = (count == rollover_val);

endmodule

// File: rtl/fir_host_sequencer.sv
// Host-side handshake sequencer feeding samples and coefficient sets to an FIR controller.
module fir_host_sequencer
    import fir_pkg::*;
#(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              sample_valid,
    output logic              sample_ready,
    input  logic [DATA_W-1:0] coeff_in,
    input  logic              coeff_valid,
    output logic              coeff_ready,
    input  logic              modwait,
    input  logic              err,
    input  logic [DATA_W-1:0] fir_out,
    output logic [DATA_W-1:0] sample_data,
    output logic [DATA_W-1:0] fir_coefficient,
    output logic              data_ready,
    output logic              load_coeff,
    output logic [DATA_W-1:0] result,
    output logic              result_valid,
    output logic              result_err,
    output logic              coeff_done,
    output logic              busy
);

    localparam int unsigned           CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]      TO_VAL   = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_COEFF - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             in_hold;
    logic             timed_out;

    // Counter sits at zero outside the hold states, so each hold starts a fresh window.
    assign in_hold = (state == DR_HOLD) || (state == LC_HOLD);

    flex_counter #(
        .WIDTH(CNT_W)
    ) u_timeout (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (!in_hold),
        .count_enable (in_hold),
        .rollover_val (TO_VAL),
        .rollover_flag(timed_out)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state           <= IDLE;
            idx             <= '0;
            sample_ready    <= 1'b0;
            coeff_ready     <= 1'b0;
            sample_data     <= '0;
            fir_coefficient <= '0;
            data_ready      <= 1'b0;
            load_coeff      <= 1'b0;
            result          <= '0;
            result_valid    <= 1'b0;
            result_err      <= 1'b0;
            coeff_done      <= 1'b0;
            busy            <= 1'b0;
        end else begin
            sample_ready <= 1'b0;
            coeff_ready  <= 1'b0;
            result_valid <= 1'b0;
            coeff_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_valid) begin
                        sample_ready <= 1'b1;
                        sample_data  <= sample_in;
                        data_ready   <= 1'b1;
                        busy         <= 1'b1;
                        state        <= DR_HOLD;
                    end else if (coeff_valid) begin
                        coeff_ready     <= 1'b1;
                        fir_coefficient <= coeff_in;
                        idx             <= '0;
                        load_coeff      <= 1'b1;
                        busy            <= 1'b1;
                        state           <= LC_HOLD;
                    end
                end
                DR_HOLD: begin
                    if (modwait) begin
                        data_ready <= 1'b0;
                        state      <= DR_RUN;
                    end else if (timed_out) begin
                        data_ready   <= 1'b0;
                        result_err   <= 1'b1;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                DR_RUN: begin
                    if (!modwait) begin
                        result       <= fir_out;
                        result_err   <= err;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= IDLE;
                    end
                end
                LC_ACCEPT: begin
                    if (coeff_valid) begin
                        coeff_ready     <= 1'b1;
                        fir_coefficient <= coeff_in;
                        load_coeff      <= 1'b1;
                        state           <= LC_HOLD;
                    end
                end
                LC_HOLD: begin
                    if (modwait) begin
                        load_coeff <= 1'b0;
                        state      <= LC_RUN;
                    end else if (timed_out) begin
                        load_coeff <= 1'b0;
                        result_err <= 1'b1;
                        coeff_done <= 1'b1;
                        idx        <= '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                LC_RUN: begin
                    if (!modwait) begin
                        if (idx == LAST_IDX) begin
                            coeff_done <= 1'b1;
                            idx        <= '0;
                            busy       <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= LC_ACCEPT;
                        end
                    end
                end
                default: begin
                    data_ready <= 1'b0;
                    load_coeff <= 1'b0;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_host_sequencer.sv
// Directed bench for fir_host_sequencer: sample, coefficient, priority, reset and timeout flows.
module tb_fir_host_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic [15:0] sample_in;
    logic        sample_valid;
    logic        sample_ready;
    logic [15:0] coeff_in;
    logic        coeff_valid;
    logic        coeff_ready;
    logic        modwait;
    logic        err;
    logic [15:0] fir_out;
    logic [15:0] sample_data;
    logic [15:0] fir_coefficient;
    logic        data_ready;
    logic        load_coeff;
    logic [15:0] result;
    logic        result_valid;
    logic        result_err;
    logic        coeff_done;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;
    int cnt;

    logic [15:0] cset [4];

    fir_host_sequencer #(
        .TIMEOUT(15)
    ) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .sample_in      (sample_in),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .coeff_in       (coeff_in),
        .coeff_valid    (coeff_valid),
        .coeff_ready    (coeff_ready),
        .modwait        (modwait),
        .err            (err),
        .fir_out        (fir_out),
        .sample_data    (sample_data),
        .fir_coefficient(fir_coefficient),
        .data_ready     (data_ready),
        .load_coeff     (load_coeff),
        .result         (result),
        .result_valid   (result_valid),
        .result_err     (result_err),
        .coeff_done     (coeff_done),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {8'h00, sample_ready, coeff_ready, sample_data, fir_coefficient, data_ready,
                load_coeff, result, result_valid, result_err, coeff_done, busy};
    endfunction

    task automatic do_load(input logic [15:0] c, input bit advance);
        coeff_in    = c;
        coeff_valid = 1'b1;
        step();
        coeff_valid = 1'b0;
        step();
        modwait = 1'b1;
        step();
        modwait = 1'b0;
        if (advance) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cset[0] = 16'h0020;
        cset[1] = 16'h0040;
        cset[2] = 16'h0040;
        cset[3] = 16'h0020;

        n_rst        = 1'b0;
        sample_in    = '0;
        sample_valid = 1'b0;
        coeff_in     = '0;
        coeff_valid  = 1'b0;
        modwait      = 1'b0;
        err          = 1'b0;
        fir_out      = '0;
        #2;
        chk("reset_async", all_outs(), 64'h0);
        step();
        chk("reset_held", all_outs(), 64'h0);
        n_rst = 1'b1;
        step();
        chk("idle_after_reset", {busy, sample_ready, coeff_ready}, 3'b000);

        // Sample flow: modwait rises one cycle after the request, stays high 10 cycles.
        sample_in    = 16'h0123;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("sample_accept", {sample_ready, data_ready, busy, sample_data},
            {1'b1, 1'b1, 1'b1, 16'h0123});
        step();
        chk("sample_dr_cycle2", {sample_ready, data_ready}, 2'b01);
        modwait = 1'b1;
        step();
        chk("sample_dr_drop", {data_ready, busy}, 2'b01);
        for (int k = 0; k < 9; k++) step();
        chk("sample_no_early_result", result_valid, 1'b0);
        modwait = 1'b0;
        fir_out = 16'h00F0;
        err     = 1'b0;
        step();
        chk("sample_result", {result_valid, result_err, busy, result},
            {1'b1, 1'b0, 1'b0, 16'h00F0});
        step();
        chk("sample_result_hold", {result_valid, result}, {1'b0, 16'h00F0});

        // Overflow reported by the controller.
        sample_in    = 16'h0BEE;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        modwait      = 1'b1;
        step();
        chk("ovf_dr_drop", data_ready, 1'b0);
        modwait = 1'b0;
        fir_out = 16'h7FFF;
        err     = 1'b1;
        step();
        chk("ovf_result", {result_valid, result_err, result}, {1'b1, 1'b1, 16'h7FFF});
        err = 1'b0;
        step();
        chk("ovf_err_hold", {result_valid, result_err}, 2'b01);

        // Full coefficient set, modwait high one cycle per load.
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                sample_valid = 1'b1;
                sample_in    = 16'hDEAD;
                step();
                sample_valid = 1'b0;
                chk("lc_accept_ignores_sample", {sample_ready, data_ready, busy, sample_data},
                    {1'b0, 1'b0, 1'b1, 16'h0BEE});
            end
            coeff_in    = cset[i];
            coeff_valid = 1'b1;
            step();
            coeff_valid = 1'b0;
            chk("lc_pulse_start", {coeff_ready, load_coeff, data_ready, fir_coefficient},
                {1'b1, 1'b1, 1'b0, cset[i]});
            step();
            chk("lc_pulse_hold", {coeff_ready, load_coeff, fir_coefficient},
                {1'b0, 1'b1, cset[i]});
            modwait = 1'b1;
            step();
            chk("lc_pulse_drop", load_coeff, 1'b0);
            modwait = 1'b0;
            step();
            chk("lc_step_done", {coeff_done, busy}, {i == 3, i != 3});
        end
        step();
        chk("lc_done_one_cycle", {coeff_done, busy}, 2'b00);

        // Priority: sample wins, pending coefficient taken after the result strobe.
        sample_in    = 16'h0555;
        coeff_in     = 16'h0AAA;
        sample_valid = 1'b1;
        coeff_valid  = 1'b1;
        step();
        sample_valid = 1'b0;
        chk("prio_accept", {sample_ready, coeff_ready, data_ready, load_coeff}, 4'b1010);
        modwait = 1'b1;
        step();
        modwait = 1'b0;
        fir_out = 16'h1234;
        step();
        chk("prio_result", {result_valid, coeff_ready, load_coeff, result},
            {1'b1, 1'b0, 1'b0, 16'h1234});
        step();
        coeff_valid = 1'b0;
        chk("prio_coeff_after", {coeff_ready, load_coeff, fir_coefficient},
            {1'b1, 1'b1, 16'h0AAA});

        // Finish load 0, load 1, then reset while in LC_RUN at index 2.
        step();
        modwait = 1'b1;
        step();
        modwait = 1'b0;
        step();
        do_load(16'h0BBB, 1'b1);
        chk("mid_set_busy", {coeff_done, busy}, 2'b01);
        do_load(16'h0CCC, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        chk("reset_mid_lc", all_outs(), 64'h0);
        step();
        chk("reset_mid_lc_held", all_outs(), 64'h0);
        n_rst = 1'b1;
        step();
        chk("reset_no_strobe", {coeff_done, result_valid, busy}, 3'b000);

        // Restart after reset needs a full set of four.
        do_load(16'h0011, 1'b1);
        do_load(16'h0022, 1'b1);
        do_load(16'h0033, 1'b1);
        chk("restart_third", {coeff_done, busy}, 2'b01);
        do_load(16'h0044, 1'b1);
        chk("restart_fourth", {coeff_done, busy, fir_coefficient}, {1'b1, 1'b0, 16'h0044});
        step();

        // Sample-request timeout.
        sample_in    = 16'h0777;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!data_ready) break;
            cnt++;
            step();
        end
        chk("dr_timeout_len", cnt, 15);
        chk("dr_timeout_flags", {result_valid, result_err, busy, coeff_done}, 4'b1100);
        step();

        // Coefficient-request timeout abandons the set.
        coeff_in    = 16'h0999;
        coeff_valid = 1'b1;
        step();
        coeff_valid = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!load_coeff) break;
            cnt++;
            step();
        end
        chk("lc_timeout_len", cnt, 15);
        chk("lc_timeout_flags", {coeff_done, result_err, busy, result_valid}, 4'b1100);
        step();

        // A clean result clears the sticky error.
        sample_in    = 16'h0999;
        sample_valid = 1'b1;
        step();
        sample_valid = 1'b0;
        modwait      = 1'b1;
        step();
        modwait = 1'b0;
        fir_out = 16'h0042;
        err     = 1'b0;
        step();
        chk("recover_result", {result_valid, result_err, result}, {1'b1, 1'b0, 16'h0042});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
